alu_mul_sequencer: RTL and testbench



---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_mul_sequencer.sv | 119 +++++++++++
 tb/tb_alu_mul_sequencer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU encodings and multiply-sequencer state constants.
// Used by alu_mul_sequencer (see ALU_MUL_EARLY_EXIT_EN there) and the surrounding datapath.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_NOP = 3'b111;

  localparam logic [1:0] SRC_ZERO  = 2'b00;
  localparam logic [1:0] SRC_ACC   = 2'b01;
  localparam logic [1:0] SRC_TWO   = 2'b10;
  localparam logic [1:0] SRC_THREE = 2'b11;

  // One-hot so every status output is a single-bit decode of the next state
  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE  = 4'b0001;
  localparam state_t ST_ADD   = 4'b0010;
  localparam state_t ST_SHIFT = 4'b0100;
  localparam state_t ST_DONE  = 4'b1000;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add 16x16 multiply sequencer (low 16 product bits) that borrows a shared external ALU.
// Optional macro ALU_MUL_EARLY_EXIT_EN: finish as soon as no multiplier bits remain.
module alu_mul_sequencer
  import alu_pkg::*;
(
  input  logic        CLK,
  input  logic        Reset_n,
  input  logic        Start,
  input  logic [15:0] OperandA,
  input  logic [15:0] OperandB,
  input  logic [15:0] ALUResult,
  output logic [1:0]  ALUSrcA,
  output logic [2:0]  ALUOp,
  output logic        AluReq,
  output logic [15:0] AccOut,
  output logic [15:0] McandOut,
  output logic        Busy,
  output logic        Done,
  output logic [15:0] Product
);

  state_t      state_r;
  state_t      state_next_s;
  logic        last_shift_s;
  logic [15:0] acc_r;
  logic [15:0] mcand_r;
  logic [15:0] mplier_r;
  logic [15:0] product_r;
  logic [3:0]  cnt_r;
  logic        busy_r;
  logic        done_r;
  logic        alu_req_r;
  logic [1:0]  src_a_r;
  logic [2:0]  alu_op_r;

  // Next-state selection; a zero multiplier with early exit falls through SHIFT straight to DONE
  always_comb begin
    state_next_s = ST_IDLE;
`ifdef ALU_MUL_EARLY_EXIT_EN
    last_shift_s = (cnt_r == 4'd15) || (mplier_r[15:1] == 15'd0);
`else
    last_shift_s = (cnt_r == 4'd15);
`endif
    case (state_r)
      ST_IDLE: begin
        if (Start) begin
          state_next_s = OperandB[0] ? ST_ADD : ST_SHIFT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ADD:   state_next_s = ST_SHIFT;
      ST_SHIFT: begin
        if (last_shift_s) begin
          state_next_s = ST_DONE;
        end else if (mplier_r[1]) begin
          state_next_s = ST_ADD;
        end else begin
          state_next_s = ST_SHIFT;
        end
      end
      ST_DONE:  state_next_s = ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // State, datapath registers and output flags registered from the next state
  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      state_r   <= ST_IDLE;
      acc_r     <= 16'd0;
      mcand_r   <= 16'd0;
      mplier_r  <= 16'd0;
      product_r <= 16'd0;
      cnt_r     <= 4'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      alu_req_r <= 1'b0;
      src_a_r   <= SRC_ZERO;
      alu_op_r  <= ALU_NOP;
    end else begin
      state_r <= state_next_s;
      case (state_r)
        ST_IDLE: begin
          if (Start) begin
            acc_r    <= 16'd0;
            mcand_r  <= OperandA;
            mplier_r <= OperandB;
            cnt_r    <= 4'd0;
          end
        end
        ST_ADD:   acc_r <= ALUResult;
        ST_SHIFT: begin
          mcand_r  <= {mcand_r[14:0], 1'b0};
          mplier_r <= {1'b0, mplier_r[15:1]};
          cnt_r    <= cnt_r + 4'd1;
        end
        ST_DONE:  product_r <= acc_r;
        default: begin
        end
      endcase
      busy_r    <= (state_next_s == ST_ADD) || (state_next_s == ST_SHIFT);
      done_r    <= (state_next_s == ST_DONE);
      alu_req_r <= (state_next_s == ST_ADD);
      src_a_r   <= (state_next_s == ST_ADD) ? SRC_ACC : SRC_ZERO;
      alu_op_r  <= (state_next_s == ST_ADD) ? ALU_ADD : ALU_NOP;
    end
  end

  assign ALUSrcA  = src_a_r;
  assign ALUOp    = alu_op_r;
  assign AluReq   = alu_req_r;
  assign AccOut   = acc_r;
  assign McandOut = mcand_r;
  assign Busy     = busy_r;
  assign Done     = done_r;
  assign Product  = product_r;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer with the shared ALU and source-A mux modelled alongside.
// Expected latencies follow ALU_MUL_EARLY_EXIT_EN when the bench is built with it.
module tb_alu_mul_sequencer;
  import alu_pkg::*;

`ifdef ALU_MUL_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic        CLK;
  logic        Reset_n;
  logic        Start;
  logic [15:0] OperandA;
  logic [15:0] OperandB;
  logic [15:0] ALUResult;
  logic [1:0]  ALUSrcA;
  logic [2:0]  ALUOp;
  logic        AluReq;
  logic [15:0] AccOut;
  logic [15:0] McandOut;
  logic        Busy;
  logic        Done;
  logic [15:0] Product;
  logic [15:0] src_a_s;

  int vec_cnt = 0;
  int err_cnt = 0;

  alu_mul_sequencer dut (
    .CLK(CLK), .Reset_n(Reset_n), .Start(Start),
    .OperandA(OperandA), .OperandB(OperandB), .ALUResult(ALUResult),
    .ALUSrcA(ALUSrcA), .ALUOp(ALUOp), .AluReq(AluReq),
    .AccOut(AccOut), .McandOut(McandOut), .Busy(Busy),
    .Done(Done), .Product(Product)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // External source-A mux and combinational ALU
  always_comb begin
    case (ALUSrcA)
      SRC_ZERO:  src_a_s = 16'd0;
      SRC_ACC:   src_a_s = AccOut;
      SRC_TWO:   src_a_s = 16'd2;
      SRC_THREE: src_a_s = 16'd3;
      default:   src_a_s = 16'd0;
    endcase
    case (ALUOp)
      ALU_ADD: ALUResult = src_a_s + McandOut;
      default: ALUResult = src_a_s;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge; issues one Start and follows the run to Done
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp_prod, input int exp_lat, input int exp_req,
                        input bit inject);
    int cyc;
    int req;
    int bad;
    int busy_after;
    bit seen;
    cyc = 0; req = 0; bad = 0; busy_after = 0; seen = 1'b0;
    OperandA = a; OperandB = b; Start = 1'b1;
    while (!seen && cyc < 60) begin
      @(posedge CLK); #1;
      cyc++;
      Start = 1'b0;
      if (inject && cyc == 5) begin
        Start = 1'b1; OperandA = 16'd7; OperandB = 16'd7;
      end
      if (AluReq) req++;
      if (( AluReq && (ALUSrcA !== SRC_ACC  || ALUOp !== ALU_ADD)) ||
          (!AluReq && (ALUSrcA !== SRC_ZERO || ALUOp !== ALU_NOP))) bad++;
      if (Done) seen = 1'b1;
    end
    chk({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    chk({tag, "_alureq"}, 32'(req), 32'(exp_req));
    chk({tag, "_ctrl"}, 32'(bad), 32'd0);
    @(posedge CLK); #1;
    chk({tag, "_pulse"}, 32'(Done), 32'd0);
    chk({tag, "_prod"}, 32'(Product), 32'(exp_prod));
    if (inject) begin
      for (int i = 0; i < 4; i++) begin
        @(posedge CLK); #1;
        if (Busy) busy_after++;
      end
      chk({tag, "_dropped"}, 32'(busy_after), 32'd0);
    end
  endtask

  initial begin
    int cyc;
    int nshift;
    int ndone;
    bit seen;
    Reset_n = 1'b0; Start = 1'b1; OperandA = 16'hFFFF; OperandB = 16'hFFFF;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy",  32'(Busy),    32'd0);
    chk("rst_done",  32'(Done),    32'd0);
    chk("rst_req",   32'(AluReq),  32'd0);
    chk("rst_src",   32'(ALUSrcA), 32'(SRC_ZERO));
    chk("rst_op",    32'(ALUOp),   32'(ALU_NOP));
    chk("rst_acc",   32'(AccOut),  32'd0);
    chk("rst_mcand", 32'(McandOut),32'd0);
    chk("rst_prod",  32'(Product), 32'd0);
    Start = 1'b0; Reset_n = 1'b1;

    run_op("a3b5",   16'd3,      16'd5,      16'h000F, EE ? 6 : 19, 2,  1'b0);
    run_op("b0010",  16'h1234,   16'h0010,   16'h2340, EE ? 7 : 18, 1,  1'b0);
    run_op("ffff",   16'hFFFF,   16'hFFFF,   16'h0001, 33,          16, 1'b0);
    run_op("b8000",  16'hABCD,   16'h8000,   16'h8000, 18,          1,  1'b0);
    run_op("bzero",  16'h5A5A,   16'h0000,   16'h0000, EE ? 2 : 17, 0,  1'b0);
    run_op("a00ff",  16'h00FF,   16'h0101,   16'hFFFF, EE ? 12 : 19, 2, 1'b0);
    run_op("inject", 16'd3,      16'd5,      16'h000F, EE ? 6 : 19, 2,  1'b1);

    // Abort a run during its 5th SHIFT cycle
    OperandA = 16'd3; OperandB = 16'h8005; Start = 1'b1;
    cyc = 0; nshift = 0; ndone = 0;
    while (nshift < 5 && cyc < 60) begin
      @(posedge CLK); #1;
      cyc++;
      Start = 1'b0;
      if (Busy && !AluReq) nshift++;
      if (Done) ndone++;
    end
    chk("abort_reach", 32'(nshift), 32'd5);
    Reset_n = 1'b0;
    @(posedge CLK); #1;
    Reset_n = 1'b1;
    chk("abort_busy", 32'(Busy),    32'd0);
    chk("abort_prod", 32'(Product), 32'd0);
    chk("abort_acc",  32'(AccOut),  32'd0);
    repeat (25) begin
      @(posedge CLK); #1;
      if (Done || Busy) ndone++;
    end
    chk("abort_nodone", 32'(ndone), 32'd0);
    run_op("after_rst", 16'd2, 16'd3, 16'h0006, EE ? 5 : 19, 2, 1'b0);

    // Start held high restarts on the first IDLE cycle after DONE
    OperandA = 16'd2; OperandB = 16'd3; Start = 1'b1;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 60) begin
      @(posedge CLK); #1;
      cyc++;
      if (Done) seen = 1'b1;
    end
    chk("hold_lat", 32'(cyc), EE ? 32'd5 : 32'd19);
    OperandA = 16'd5;
    @(posedge CLK); #1;
    chk("hold_idle", 32'(Busy),    32'd0);
    chk("hold_prod", 32'(Product), 32'h0006);
    @(posedge CLK); #1;
    chk("hold_restart", 32'(Busy), 32'd1);
    Start = 1'b0;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 60) begin
      @(posedge CLK); #1;
      cyc++;
      if (Done) seen = 1'b1;
    end
    chk("hold_done2", 32'(seen), 32'd1);
    @(posedge CLK); #1;
    chk("hold_prod2", 32'(Product), 32'h000F);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
